// File: rtl/vga_capture_receiver.sv
// VGA receive front end: locks to a fixed sync timing and streams active-area pixels through a FWFT FIFO.
// Define VGA_RX_STATS_EN to add the frame_cnt and lock_loss_cnt statistics outputs.
module vga_capture_receiver #(
  parameter int CONFIG_H_ACTIVE_SIZE      = 640,
  parameter int CONFIG_H_BACK_PORCH_SIZE  = 48,
  parameter int CONFIG_H_SYNC_PULSE_SIZE  = 96,
  parameter int CONFIG_H_FRONT_PORCH_SIZE = 16,
  parameter int CONFIG_V_ACTIVE_SIZE      = 480,
  parameter int CONFIG_V_BACK_PORCH_SIZE  = 33,
  parameter int CONFIG_V_SYNC_PULSE_SIZE  = 2,
  parameter int CONFIG_V_FRONT_PORCH_SIZE = 10,
  parameter int H_OFFSET                  = 0,
  parameter int FIFO_DEPTH                = 16
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iHS,
  input  logic        iVS,
  input  logic [3:0]  iVGA_R,
  input  logic [3:0]  iVGA_G,
  input  logic [3:0]  iVGA_B,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic [23:0] pixel_data,
  output logic        pixel_sof,
  output logic        pixel_eol,
  output logic        locked,
  output logic        overflow
`ifdef VGA_RX_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  lock_loss_cnt
`endif
);

  localparam int H_TOTAL = CONFIG_H_ACTIVE_SIZE + CONFIG_H_BACK_PORCH_SIZE +
                           CONFIG_H_SYNC_PULSE_SIZE + CONFIG_H_FRONT_PORCH_SIZE;
  localparam int V_TOTAL = CONFIG_V_ACTIVE_SIZE + CONFIG_V_BACK_PORCH_SIZE +
                           CONFIG_V_SYNC_PULSE_SIZE + CONFIG_V_FRONT_PORCH_SIZE;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam logic [31:0] H_START = 32'(CONFIG_H_SYNC_PULSE_SIZE + CONFIG_H_BACK_PORCH_SIZE + H_OFFSET);
  localparam logic [31:0] H_END   = H_START + 32'(CONFIG_H_ACTIVE_SIZE);
  localparam logic [31:0] V_START = 32'(CONFIG_V_SYNC_PULSE_SIZE + CONFIG_V_BACK_PORCH_SIZE);
  localparam logic [31:0] V_END   = V_START + 32'(CONFIG_V_ACTIVE_SIZE);

  localparam logic [1:0] SEARCH = 2'b00;
  localparam logic [1:0] VERIFY = 2'b01;
  localparam logic [1:0] LOCKED = 2'b11;

  logic          hs_r, hs_d, vs_r, vs_d;
  logic [3:0]    r_r, g_r, b_r;
  logic          hs_edge, vs_edge, ln_reset, line_ok, frame_ok;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] ln;
  logic          vs_pend;
  logic [1:0]    state, state_nxt;
  logic [31:0]   h_x, ln_x;
  logic          in_window, sof_w, eol_w, wr_req, wr_en, rd_en;
  logic [25:0]   wr_data, head;
  logic [25:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hs_r <= 1'b0;
      hs_d <= 1'b0;
      vs_r <= 1'b0;
      vs_d <= 1'b0;
      r_r  <= '0;
      g_r  <= '0;
      b_r  <= '0;
    end else begin
      hs_r <= iHS;
      hs_d <= hs_r;
      vs_r <= iVS;
      vs_d <= vs_r;
      r_r  <= iVGA_R;
      g_r  <= iVGA_G;
      b_r  <= iVGA_B;
    end
  end

  assign hs_edge  = hs_d & ~hs_r;
  assign vs_edge  = vs_d & ~vs_r;
  assign ln_reset = hs_edge & (vs_pend | vs_edge);
  assign line_ok  = (h_cnt == H_LAST);
  assign frame_ok = (ln == V_LAST);

  // h_cnt/ln stay aligned with the registered pixel, so the window below lines up with r_r/g_r/b_r
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h_cnt   <= '0;
      ln      <= '0;
      vs_pend <= 1'b0;
    end else begin
      if (hs_edge) h_cnt <= '0;
      else if (h_cnt != H_MAX) h_cnt <= h_cnt + 1'b1;
      if (hs_edge) vs_pend <= 1'b0;
      else if (vs_edge) vs_pend <= 1'b1;
      if (hs_edge) begin
        if (vs_pend || vs_edge) ln <= '0;
        else if (ln != V_MAX) ln <= ln + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: if (ln_reset) state_nxt = VERIFY;
      VERIFY: begin
        if (hs_edge && !line_ok) state_nxt = SEARCH;
        else if (ln_reset) state_nxt = frame_ok ? LOCKED : VERIFY;
      end
      LOCKED: if ((hs_edge && !line_ok) || (ln_reset && !frame_ok)) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state  <= SEARCH;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      locked <= (state_nxt == LOCKED);
    end
  end

  assign h_x       = 32'(h_cnt);
  assign ln_x      = 32'(ln);
  assign in_window = (h_x >= H_START) && (h_x < H_END) && (ln_x >= V_START) && (ln_x < V_END);
  assign sof_w     = (h_x == H_START) && (ln_x == V_START);
  assign eol_w     = (h_x == H_END - 32'd1);
  // Requiring LOCKED in both cycles keeps the edge that breaks lock out of the FIFO
  assign wr_req    = (state == LOCKED) && (state_nxt == LOCKED) && in_window;
  assign wr_data   = {sof_w, eol_w, b_r, b_r, g_r, g_r, r_r, r_r};

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = !empty && pixel_ready;
  assign wr_en = wr_req && (!full || rd_en);

  always_ff @(posedge iVGA_CLK) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_req && !wr_en) overflow <= 1'b1;
    end
  end

  assign head        = mem[rd_ptr[AW-1:0]];
  assign pixel_valid = !empty;
  assign pixel_data  = empty ? 24'd0 : head[23:0];
  assign pixel_sof   = !empty && head[25];
  assign pixel_eol   = !empty && head[24];

`ifdef VGA_RX_STATS_EN
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      frame_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else begin
      if (ln_reset && state == LOCKED) frame_cnt <= frame_cnt + 1'b1;
      if (state == LOCKED && state_nxt == SEARCH && lock_loss_cnt != 8'hFF)
        lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_capture_receiver.sv
// Scoreboard bench for vga_capture_receiver: a line-level lock model predicts captured pixels,
// a negedge monitor pops and compares whatever the DUT streams out.
module tb_vga_capture_receiver;

  localparam int H_ACT = 8, H_BP = 2, H_SYNC = 3, H_FP = 1;
  localparam int V_ACT = 4, V_BP = 1, V_SYNC = 2, V_FP = 1;
  localparam int H_OFF = 0, DEPTH = 16;
  localparam int H_TOTAL = H_ACT + H_BP + H_SYNC + H_FP;
  localparam int V_TOTAL = V_ACT + V_BP + V_SYNC + V_FP;
  localparam int H_START = H_SYNC + H_BP + H_OFF;
  localparam int H_END   = H_START + H_ACT;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_END   = V_START + V_ACT;
  localparam int M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic        clk, rst_n, hs, vs;
  logic [3:0]  r, g, b;
  logic        pixel_valid, pixel_ready, pixel_sof, pixel_eol, locked, overflow;
  logic [23:0] pixel_data;
`ifdef VGA_RX_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  lock_loss_cnt;
`endif

  int checks = 0, errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  logic [25:0] exp_q[$];
  int pop_cnt = 0, sof_cnt = 0, eol_cnt = 0;
  int m_state = M_SEARCH, prev_len = -1, non_reset_edges = -1;
  bit lat_armed = 0, lat_done = 0;
  int first_drive_cyc = 0;

  vga_capture_receiver #(
    .CONFIG_H_ACTIVE_SIZE(H_ACT), .CONFIG_H_BACK_PORCH_SIZE(H_BP),
    .CONFIG_H_SYNC_PULSE_SIZE(H_SYNC), .CONFIG_H_FRONT_PORCH_SIZE(H_FP),
    .CONFIG_V_ACTIVE_SIZE(V_ACT), .CONFIG_V_BACK_PORCH_SIZE(V_BP),
    .CONFIG_V_SYNC_PULSE_SIZE(V_SYNC), .CONFIG_V_FRONT_PORCH_SIZE(V_FP),
    .H_OFFSET(H_OFF), .FIFO_DEPTH(DEPTH)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iHS(hs), .iVS(vs),
    .iVGA_R(r), .iVGA_G(g), .iVGA_B(b),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_data(pixel_data),
    .pixel_sof(pixel_sof), .pixel_eol(pixel_eol), .locked(locked), .overflow(overflow)
`ifdef VGA_RX_STATS_EN
    , .frame_cnt(frame_cnt), .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic hs_v, input logic vs_v, input logic [3:0] r_v,
                               input logic [3:0] g_v, input logic [3:0] b_v);
    @(posedge clk);
    #1;
    hs = hs_v;
    vs = vs_v;
    r  = r_v;
    g  = g_v;
    b  = b_v;
    case (ready_mode)
      0:       pixel_ready = 1'b1;
      1:       pixel_ready = 1'b0;
      default: pixel_ready = ($urandom_range(3, 0) != 0);
    endcase
  endtask

  // Lock rules evaluated once per line start; a frame start is a line that begins with VS falling
  task automatic modelEdge(input bit frame_start);
    bit line_ok, frame_ok;
    line_ok  = (prev_len == H_TOTAL);
    frame_ok = (non_reset_edges == V_TOTAL - 1);
    case (m_state)
      M_SEARCH: if (frame_start) m_state = M_VERIFY;
      M_VERIFY: begin
        if (!line_ok) m_state = M_SEARCH;
        else if (frame_start) m_state = frame_ok ? M_LOCKED : M_VERIFY;
      end
      default: if (!line_ok || (frame_start && !frame_ok)) m_state = M_SEARCH;
    endcase
    if (frame_start) non_reset_edges = 0;
    else non_reset_edges++;
  endtask

  task automatic modelReset();
    m_state = M_SEARCH;
    prev_len = -1;
    non_reset_edges = -1;
    exp_q.delete();
  endtask

  // The receiver counter reads 0 one pixel after the HS fall, so pixel position p sits at count p-1
  task automatic sendFrame(input int long_line, input bit const_color, input int stop_after);
    int pushed, len, hc;
    bit cap;
    logic [3:0] cr, cg, cb;
    pushed = 0;
    for (int l = 0; l < V_TOTAL; l++) begin
      len = (l == long_line) ? H_TOTAL + 1 : H_TOTAL;
      modelEdge(l == 0);
      prev_len = len;
      for (int p = 0; p < len; p++) begin
        if (const_color) begin
          cr = 4'hA; cg = 4'h5; cb = 4'hF;
        end else begin
          cr = 4'($urandom_range(15, 0));
          cg = 4'($urandom_range(15, 0));
          cb = 4'($urandom_range(15, 0));
        end
        hc  = p - 1;
        cap = (m_state == M_LOCKED) && (p >= 1) && (hc >= H_START) && (hc < H_END) &&
              (l >= V_START) && (l < V_END);
        if (cap && ready_mode == 1 && exp_q.size() >= DEPTH) cap = 0;
        if (cap) begin
          exp_q.push_back({(hc == H_START && l == V_START), (hc == H_END - 1), cb, cb, cg, cg, cr, cr});
          pushed++;
        end
        applyStimulus(p >= H_SYNC, l >= V_SYNC, cr, cg, cb);
        if (cap && !lat_done) begin
          first_drive_cyc = cyc;
          lat_armed = 1;
          lat_done  = 1;
        end
        if (stop_after >= 0 && pushed == stop_after) return;
      end
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks the head holds while stalled
  initial begin
    logic [25:0] cur, held, exp;
    bit holding;
    holding = 0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = {pixel_sof, pixel_eol, pixel_data};
      if (!rst_n) begin
        holding = 0;
      end else begin
        if (holding && pixel_valid) checkOutput("stall_stable", {6'd0, cur}, {6'd0, held});
        if (pixel_valid && lat_armed) begin
          checkOutput("latency", 32'(cyc - first_drive_cyc), 32'd2);
          lat_armed = 0;
        end
        if (pixel_valid && pixel_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_pixel", {6'd0, cur}, 32'hFFFF_FFFF);
          end else begin
            exp = exp_q.pop_front();
            checkOutput("pixel", {6'd0, cur}, {6'd0, exp});
            pop_cnt++;
            if (cur[25]) sof_cnt++;
            if (cur[24]) eol_cnt++;
          end
        end
        holding = pixel_valid && !pixel_ready;
        held = cur;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0, s0, e0;
    rst_n = 1'b0;
    hs = 1'b1; vs = 1'b1; r = '0; g = '0; b = '0;
    pixel_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(pixel_valid), 32'd0);
    checkOutput("reset_locked", 32'(locked), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_data", 32'(pixel_data), 32'd0);
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);

    $display("[TB] clean frames");
    sendFrame(-1, 0, -1);
    checkOutput("locked_after_f1", 32'(locked), 32'd0);
    p0 = pop_cnt; s0 = sof_cnt; e0 = eol_cnt;
    sendFrame(-1, 0, -1);
    checkOutput("locked_after_f2", 32'(locked), 32'd1);
    sendFrame(-1, 0, -1);
    checkOutput("pixels_f2_f3", 32'(pop_cnt - p0), 32'd64);
    checkOutput("sof_f2_f3", 32'(sof_cnt - s0), 32'd2);
    checkOutput("eol_f2_f3", 32'(eol_cnt - e0), 32'd8);

    $display("[TB] constant colour frame");
    p0 = pop_cnt;
    sendFrame(-1, 1, -1);
    checkOutput("pixels_const", 32'(pop_cnt - p0), 32'd32);
    checkOutput("overflow_before_stall", 32'(overflow), 32'd0);

    $display("[TB] stalled frame");
    ready_mode = 1;
    sendFrame(-1, 0, -1);
    checkOutput("overflow_after_stall", 32'(overflow), 32'd1);
    checkOutput("valid_after_stall", 32'(pixel_valid), 32'd1);
    checkOutput("queued_after_stall", 32'(exp_q.size()), 32'd16);
    ready_mode = 2;
    sendFrame(-1, 0, -1);

    $display("[TB] long line glitch");
    ready_mode = 0;
    sendFrame(4, 0, -1);
    checkOutput("locked_after_glitch", 32'(locked), 32'd0);
    sendFrame(-1, 0, -1);
    checkOutput("locked_after_verify", 32'(locked), 32'd0);
    sendFrame(-1, 0, -1);
    checkOutput("relocked", 32'(locked), 32'd1);

    $display("[TB] reset with buffered pixels");
    ready_mode = 1;
    sendFrame(-1, 0, 5);
    applyStimulus(1'b1, 1'b1, 4'h3, 4'h4, 4'h5);
    @(posedge clk);
    #2;
    checkOutput("buffered_valid", 32'(pixel_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(pixel_valid), 32'd0);
    checkOutput("async_locked", 32'(locked), 32'd0);
    checkOutput("async_overflow", 32'(overflow), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (3) applyStimulus(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
    sendFrame(-1, 0, -1);
    checkOutput("locked_after_reset_f1", 32'(locked), 32'd0);
    sendFrame(-1, 0, -1);
    checkOutput("locked_after_reset_f2", 32'(locked), 32'd1);
    sendFrame(-1, 0, -1);
    sendFrame(-1, 0, -1);
    sendFrame(-1, 0, -1);
    sendFrame(2, 0, -1);
    checkOutput("locked_after_glitch2", 32'(locked), 32'd0);
`ifdef VGA_RX_STATS_EN
    checkOutput("frame_cnt", 32'(frame_cnt), 32'd4);
    checkOutput("lock_loss_cnt", 32'(lock_loss_cnt), 32'd1);
`endif

    for (int i = 0; i < 100 && exp_q.size() != 0; i++)
      applyStimulus(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
    repeat (4) applyStimulus(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
    checkOutput("drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
